// File: rtl/flist_arb.sv
// ---------------------------------------------------------------------------
// flist_arb
//   Front end that lets NREQ client engines share a single free-list
//   allocator. Allocation and deallocation travel on independent channels,
//   each with its own round-robin arbiter and three-state machine
//   (IDLE -> WAIT -> GNT). Each requester may hold at most QUOTA IDs. Its
//   current holding is exported on held_cnt.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_alloc       : per-requester alloc request level (held until grant)
//   gnt_alloc       : one-hot, one-cycle alloc grant
//   alloc_id        : allocated ID, valid alongside gnt_alloc
//   req_dealloc     : per-requester dealloc request level (held until grant)
//   dealloc_id_in   : requester i's ID to return on bits [i*IDW +: IDW]
//   gnt_dealloc     : one-hot, one-cycle dealloc completion
//   fl_alloc_req    : one-cycle alloc pulse towards the free list
//   fl_alloc_ack    : free-list alloc acknowledge, fl_alloc_id valid with it
//   fl_alloc_id     : ID returned by the free list
//   fl_dealloc_req  : one-cycle dealloc pulse towards the free list
//   fl_dealloc_id   : ID being returned, stable until fl_dealloc_ack
//   fl_dealloc_ack  : free-list dealloc acknowledge
//   fl_init_done    : free list ready; gates new alloc issue only
//   held_cnt        : per-requester held-ID counts, CNTW bits each
//   err_underflow   : sticky, a dealloc completed for a requester holding 0
// ---------------------------------------------------------------------------
module flist_arb #(
  parameter int NREQ  = 4,
  parameter int IDW   = 16,
  parameter int QUOTA = 8,
  parameter int CNTW  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_alloc,
  output logic [NREQ-1:0]      gnt_alloc,
  output logic [IDW-1:0]       alloc_id,
  input  logic [NREQ-1:0]      req_dealloc,
  input  logic [NREQ*IDW-1:0]  dealloc_id_in,
  output logic [NREQ-1:0]      gnt_dealloc,
  output logic                 fl_alloc_req,
  input  logic                 fl_alloc_ack,
  input  logic [IDW-1:0]       fl_alloc_id,
  output logic                 fl_dealloc_req,
  output logic [IDW-1:0]       fl_dealloc_id,
  input  logic                 fl_dealloc_ack,
  input  logic                 fl_init_done,
  output logic [NREQ*CNTW-1:0] held_cnt,
  output logic                 err_underflow
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNTW-1:0] QUOTA_C  = CNTW'(QUOTA);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GNT
  } chanState_e;

  chanState_e      allocState_q;
  chanState_e      deallocState_q;
  logic [IDXW-1:0] allocWinner_q;
  logic [IDXW-1:0] deallocWinner_q;
  logic [IDXW-1:0] allocPtr_q;
  logic [IDXW-1:0] deallocPtr_q;
  logic [CNTW-1:0] heldCnt_q [NREQ];
  logic [CNTW-1:0] heldCnt_d [NREQ];

  logic [NREQ-1:0] allocElig;
  logic [IDXW-1:0] allocPick;
  logic [IDXW-1:0] deallocPick;
  logic [IDW-1:0]  deallocPickId;
  logic            allocDone;
  logic            deallocDone;
  logic            underflowHit;

  // First eligible index at or after ptr, wrapping from NREQ-1 back to 0.
  // Only meaningful when at least one bit of elig is set.
  function automatic logic [IDXW-1:0] rrPick(input logic [NREQ-1:0] elig,
                                             input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] pick;
    logic            found;
    int              idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[IDXW'(idx)]) begin
        pick  = IDXW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDXW-1:0] rrNext(input logic [IDXW-1:0] w);
    return (w == LAST_IDX) ? '0 : w + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] oneHot(input logic [IDXW-1:0] w);
    logic [NREQ-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // A requester already at its quota is invisible to the alloc arbiter.
  always_comb begin
    allocElig = '0;
    for (int i = 0; i < NREQ; i++) begin
      allocElig[i] = req_alloc[i] && (heldCnt_q[i] < QUOTA_C);
    end
  end

  assign allocPick   = rrPick(allocElig, allocPtr_q);
  assign deallocPick = rrPick(req_dealloc, deallocPtr_q);

  always_comb begin
    deallocPickId = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (deallocPick == IDXW'(i)) deallocPickId = dealloc_id_in[i*IDW +: IDW];
    end
  end

  // Acks only count while the channel is waiting; in IDLE or GNT they are dropped.
  assign allocDone   = (allocState_q == ST_WAIT) && fl_alloc_ack;
  assign deallocDone = (deallocState_q == ST_WAIT) && fl_dealloc_ack;

  // Alloc channel. The grant and the count bump land on the same edge, so
  // the next arbitration round already sees the updated holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      allocState_q  <= ST_IDLE;
      allocWinner_q <= '0;
      allocPtr_q    <= '0;
      fl_alloc_req  <= 1'b0;
      gnt_alloc     <= '0;
      alloc_id      <= '0;
    end else begin
      fl_alloc_req <= 1'b0;
      gnt_alloc    <= '0;
      case (allocState_q)
        ST_IDLE: begin
          if (fl_init_done && (|allocElig)) begin
            allocWinner_q <= allocPick;
            fl_alloc_req  <= 1'b1;
            allocState_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fl_alloc_ack) begin
            gnt_alloc    <= oneHot(allocWinner_q);
            alloc_id     <= fl_alloc_id;
            allocPtr_q   <= rrNext(allocWinner_q);
            allocState_q <= ST_GNT;
          end
        end
        ST_GNT:  allocState_q <= ST_IDLE;
        default: allocState_q <= ST_IDLE;
      endcase
    end
  end

  // Dealloc channel. The returned ID is captured at issue, so the requester's
  // slice may change after the grant without disturbing the free list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deallocState_q  <= ST_IDLE;
      deallocWinner_q <= '0;
      deallocPtr_q    <= '0;
      fl_dealloc_req  <= 1'b0;
      fl_dealloc_id   <= '0;
      gnt_dealloc     <= '0;
    end else begin
      fl_dealloc_req <= 1'b0;
      gnt_dealloc    <= '0;
      case (deallocState_q)
        ST_IDLE: begin
          if (|req_dealloc) begin
            deallocWinner_q <= deallocPick;
            fl_dealloc_id   <= deallocPickId;
            fl_dealloc_req  <= 1'b1;
            deallocState_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fl_dealloc_ack) begin
            gnt_dealloc    <= oneHot(deallocWinner_q);
            deallocPtr_q   <= rrNext(deallocWinner_q);
            deallocState_q <= ST_GNT;
          end
        end
        ST_GNT:  deallocState_q <= ST_IDLE;
        default: deallocState_q <= ST_IDLE;
      endcase
    end
  end

  // Count bookkeeping. An alloc and a dealloc finishing together for the
  // same requester cancel out; a lone dealloc at zero saturates and flags.
  always_comb begin : cntNext
    logic incr;
    logic decr;
    underflowHit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      heldCnt_d[i] = heldCnt_q[i];
      incr = allocDone && (allocWinner_q == IDXW'(i));
      decr = deallocDone && (deallocWinner_q == IDXW'(i));
      if (incr && !decr) begin
        heldCnt_d[i] = heldCnt_q[i] + 1'b1;
      end else if (decr && !incr) begin
        if (heldCnt_q[i] == '0) underflowHit = 1'b1;
        else                    heldCnt_d[i] = heldCnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) heldCnt_q[i] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) heldCnt_q[i] <= heldCnt_d[i];
      err_underflow <= err_underflow | underflowHit;
    end
  end

  always_comb begin
    held_cnt = '0;
    for (int i = 0; i < NREQ; i++) held_cnt[i*CNTW +: CNTW] = heldCnt_q[i];
  end

endmodule

// File: tb/tb_flist_arb.sv
// ---------------------------------------------------------------------------
// tb_flist_arb
//   Bench for flist_arb. A transaction-level reference model tracks which
//   requester each channel is serving, the grant due next cycle, both
//   round-robin pointers and every requester's holding. A negedge process
//   compares the DUT against it every cycle. Directed scenarios add literal
//   expectations, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_flist_arb;
  localparam int NREQ  = 4;
  localparam int IDW   = 16;
  localparam int QUOTA = 8;
  localparam int CNTW  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_alloc = '0;
  logic [NREQ-1:0]      gnt_alloc;
  logic [IDW-1:0]       alloc_id;
  logic [NREQ-1:0]      req_dealloc = '0;
  logic [NREQ*IDW-1:0]  dealloc_id_in = '0;
  logic [NREQ-1:0]      gnt_dealloc;
  logic                 fl_alloc_req;
  logic                 fl_alloc_ack = 1'b0;
  logic [IDW-1:0]       fl_alloc_id = '0;
  logic                 fl_dealloc_req;
  logic [IDW-1:0]       fl_dealloc_id;
  logic                 fl_dealloc_ack = 1'b0;
  logic                 fl_init_done = 1'b0;
  logic [NREQ*CNTW-1:0] held_cnt;
  logic                 err_underflow;

  int compared   = 0;
  int mismatched = 0;
  int cycleNo    = 0;

  // Free-list emulation controls
  bit autoAck = 1'b0;
  int ackMin  = 1;
  int ackMax  = 1;
  int aPend   = -1;
  int dPend   = -1;

  flist_arb #(.NREQ(NREQ), .IDW(IDW), .QUOTA(QUOTA), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_alloc(req_alloc), .gnt_alloc(gnt_alloc), .alloc_id(alloc_id),
    .req_dealloc(req_dealloc), .dealloc_id_in(dealloc_id_in), .gnt_dealloc(gnt_dealloc),
    .fl_alloc_req(fl_alloc_req), .fl_alloc_ack(fl_alloc_ack), .fl_alloc_id(fl_alloc_id),
    .fl_dealloc_req(fl_dealloc_req), .fl_dealloc_id(fl_dealloc_id), .fl_dealloc_ack(fl_dealloc_ack),
    .fl_init_done(fl_init_done), .held_cnt(held_cnt), .err_underflow(err_underflow)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  // ---------------- reference model ----------------
  // mXWait: requester whose op is out at the free list (-1 none)
  // mXGnt : requester whose grant is visible this cycle (-1 none)
  int              mAWait, mAGnt, mAPtr, mDWait, mDGnt, mDPtr;
  bit              mAPulse, mDPulse, mErr;
  logic [IDW-1:0]  mAId, mDId;
  int              mCnt [NREQ];

  // Advance the model one clock using the inputs as sampled at the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mAWait = -1; mAGnt = -1; mAPtr = 0; mAPulse = 0; mAId = '0;
      mDWait = -1; mDGnt = -1; mDPtr = 0; mDPulse = 0; mDId = '0;
      mErr = 0;
      for (int i = 0; i < NREQ; i++) mCnt[i] = 0;
    end else begin : modelStep
      int nAGnt, nDGnt, inc, dec, r;
      bit nAP, nDP;
      nAGnt = -1; nDGnt = -1; inc = -1; dec = -1; nAP = 0; nDP = 0;
      if (mAWait >= 0) begin
        if (fl_alloc_ack) begin
          nAGnt = mAWait; mAId = fl_alloc_id; inc = mAWait;
          mAPtr = (mAWait + 1) % NREQ; mAWait = -1;
        end
      end else if (mAGnt < 0 && fl_init_done) begin
        for (int k = 0; k < NREQ; k++) begin
          r = (mAPtr + k) % NREQ;
          if (!nAP && req_alloc[2'(r)] && mCnt[r] < QUOTA) begin
            mAWait = r; nAP = 1;
          end
        end
      end
      if (mDWait >= 0) begin
        if (fl_dealloc_ack) begin
          nDGnt = mDWait; dec = mDWait;
          mDPtr = (mDWait + 1) % NREQ; mDWait = -1;
        end
      end else if (mDGnt < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          r = (mDPtr + k) % NREQ;
          if (!nDP && req_dealloc[2'(r)]) begin
            mDWait = r; nDP = 1; mDId = dealloc_id_in[r*IDW +: IDW];
          end
        end
      end
      if (!(inc >= 0 && inc == dec)) begin
        if (inc >= 0) mCnt[inc] = mCnt[inc] + 1;
        if (dec >= 0) begin
          if (mCnt[dec] == 0) mErr = 1;
          else                mCnt[dec] = mCnt[dec] - 1;
        end
      end
      mAGnt = nAGnt; mDGnt = nDGnt; mAPulse = nAP; mDPulse = nDP;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin : compareProc
    logic [NREQ-1:0] expGA, expGD;
    expGA = (mAGnt >= 0) ? (NREQ'(1) << mAGnt) : '0;
    expGD = (mDGnt >= 0) ? (NREQ'(1) << mDGnt) : '0;
    checkOutput("model gnt_alloc", gnt_alloc, expGA);
    checkOutput("model gnt_dealloc", gnt_dealloc, expGD);
    checkOutput("model fl_alloc_req", fl_alloc_req, mAPulse);
    checkOutput("model fl_dealloc_req", fl_dealloc_req, mDPulse);
    if (mAGnt >= 0) checkOutput("model alloc_id", alloc_id, mAId);
    if (mDWait >= 0) checkOutput("model fl_dealloc_id", fl_dealloc_id, mDId);
    for (int i = 0; i < NREQ; i++) checkOutput("model held_cnt", held_cnt[i*CNTW +: CNTW], mCnt[i]);
    checkOutput("model err_underflow", err_underflow, mErr);
  end

  // ---------------- stimulus ----------------
  // Advance one clock and land 1 time unit after the edge; when enabled,
  // play the free list and ack each pulse after a chosen delay.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cycleNo++;
    if (autoAck) begin
      fl_alloc_ack   = 1'b0;
      fl_dealloc_ack = 1'b0;
      if (aPend > 0) aPend--;
      if (fl_alloc_req) aPend = int'($urandom_range(ackMax, ackMin));
      if (aPend == 0) begin
        fl_alloc_ack = 1'b1; fl_alloc_id = IDW'($urandom); aPend = -1;
      end
      if (dPend > 0) dPend--;
      if (fl_dealloc_req) dPend = int'($urandom_range(ackMax, ackMin));
      if (dPend == 0) begin
        fl_dealloc_ack = 1'b1; dPend = -1;
      end
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req_alloc = '0; req_dealloc = '0;
    fl_alloc_ack = 1'b0; fl_dealloc_ack = 1'b0;
    aPend = -1; dPend = -1;
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
  endtask

  initial begin : mainSeq
    bit              sawReq, seen;
    int              nG, startCyc;
    logic [NREQ-1:0] order [5];
    int              gCyc [5];
    logic [NREQ-1:0] expOrder [5];
    bit              spacingOk;

    // Reset state
    applyReset();
    applyStimulus();
    checkOutput("reset gnt_alloc", gnt_alloc, 0);
    checkOutput("reset held_cnt", held_cnt, 0);
    checkOutput("reset err_underflow", err_underflow, 0);

    // 1: alloc gated by fl_init_done, then one full alloc with id 0x0005
    fl_init_done = 1'b0; autoAck = 1'b0;
    applyReset();
    req_alloc = 4'b0001;
    sawReq = 0;
    repeat (5) begin applyStimulus(); if (fl_alloc_req) sawReq = 1; end
    checkOutput("t1 no pulse before init", sawReq, 0);
    fl_init_done = 1'b1;
    applyStimulus();
    checkOutput("t1 pulse issued", fl_alloc_req, 1);
    applyStimulus();
    checkOutput("t1 pulse one cycle", fl_alloc_req, 0);
    fl_alloc_ack = 1'b1; fl_alloc_id = 16'h0005;
    applyStimulus();
    fl_alloc_ack = 1'b0;
    checkOutput("t1 gnt_alloc", gnt_alloc, 4'b0001);
    checkOutput("t1 alloc_id", alloc_id, 16'h0005);
    checkOutput("t1 held_cnt0", held_cnt[3:0], 1);
    req_alloc = '0;
    applyStimulus();
    checkOutput("t1 grant one cycle", gnt_alloc, 0);

    // 2: all four requesting, ack one cycle after each pulse
    applyReset();
    autoAck = 1'b1; ackMin = 1; ackMax = 1;
    req_alloc = 4'b1111;
    startCyc = cycleNo; nG = 0;
    for (int c = 0; c < 60 && nG < 5; c++) begin
      applyStimulus();
      if (gnt_alloc != 0) begin order[nG] = gnt_alloc; gCyc[nG] = cycleNo; nG++; end
    end
    checkOutput("t2 grants seen", nG, 5);
    expOrder[0] = 4'b0001; expOrder[1] = 4'b0010; expOrder[2] = 4'b0100;
    expOrder[3] = 4'b1000; expOrder[4] = 4'b0001;
    spacingOk = 1;
    for (int i = 0; i < nG; i++) begin
      checkOutput("t2 grant order", order[i], expOrder[i]);
      if (i > 0 && gCyc[i] - gCyc[i-1] < 3) spacingOk = 0;
    end
    if (nG > 0) checkOutput("t2 first latency", gCyc[0] - startCyc, 3);
    checkOutput("t2 spacing at least 3", spacingOk, 1);
    req_alloc = '0;
    repeat (8) applyStimulus();

    // 3: quota of 8 for requester 2, dealloc 0x0003 reopens it
    applyReset();
    req_alloc = 4'b0100; nG = 0;
    for (int c = 0; c < 100 && nG < 8; c++) begin
      applyStimulus();
      if (gnt_alloc[2]) nG++;
    end
    checkOutput("t3 eight grants", nG, 8);
    sawReq = 0;
    repeat (8) begin applyStimulus(); if (fl_alloc_req) sawReq = 1; end
    checkOutput("t3 quota blocks 9th", sawReq, 0);
    checkOutput("t3 held_cnt2 full", held_cnt[11:8], 8);
    dealloc_id_in[2*IDW +: IDW] = 16'h0003;
    req_dealloc = 4'b0100;
    applyStimulus();
    checkOutput("t3 dealloc pulse", fl_dealloc_req, 1);
    checkOutput("t3 dealloc id", fl_dealloc_id, 16'h0003);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin applyStimulus(); if (gnt_dealloc != 0) seen = 1; end
    checkOutput("t3 gnt_dealloc", gnt_dealloc, 4'b0100);
    checkOutput("t3 held_cnt2 after dealloc", held_cnt[11:8], 7);
    req_dealloc = '0;
    sawReq = 0;
    for (int c = 0; c < 6 && !sawReq; c++) begin applyStimulus(); if (fl_alloc_req) sawReq = 1; end
    checkOutput("t3 ninth alloc issues", sawReq, 1);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin applyStimulus(); if (gnt_alloc[2]) seen = 1; end
    checkOutput("t3 ninth grant", seen, 1);
    req_alloc = '0;
    repeat (4) applyStimulus();

    // 4: underflow from requester 1 at zero is sticky until reset
    applyReset();
    dealloc_id_in[1*IDW +: IDW] = 16'h0009;
    req_dealloc = 4'b0010; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin applyStimulus(); if (gnt_dealloc != 0) seen = 1; end
    checkOutput("t4 gnt_dealloc", gnt_dealloc, 4'b0010);
    checkOutput("t4 held_cnt1 stays 0", held_cnt[7:4], 0);
    checkOutput("t4 err_underflow set", err_underflow, 1);
    req_dealloc = '0;
    repeat (5) applyStimulus();
    checkOutput("t4 err_underflow sticky", err_underflow, 1);
    applyReset();
    applyStimulus();
    checkOutput("t4 err_underflow cleared", err_underflow, 0);

    // 5: simultaneous alloc and dealloc completion for requester 3 at count 2
    req_alloc = 4'b1000; nG = 0;
    for (int c = 0; c < 30 && nG < 2; c++) begin
      applyStimulus();
      if (gnt_alloc[3]) nG++;
    end
    req_alloc = '0;
    repeat (3) applyStimulus();
    checkOutput("t5 held_cnt3 before", held_cnt[15:12], 2);
    autoAck = 1'b0; aPend = -1; dPend = -1;
    fl_alloc_ack = 1'b0; fl_dealloc_ack = 1'b0;
    dealloc_id_in[3*IDW +: IDW] = 16'h0011;
    req_alloc = 4'b1000; req_dealloc = 4'b1000;
    applyStimulus();
    checkOutput("t5 alloc pulse", fl_alloc_req, 1);
    checkOutput("t5 dealloc pulse", fl_dealloc_req, 1);
    applyStimulus();
    fl_alloc_ack = 1'b1; fl_alloc_id = 16'h0042; fl_dealloc_ack = 1'b1;
    applyStimulus();
    fl_alloc_ack = 1'b0; fl_dealloc_ack = 1'b0;
    checkOutput("t5 gnt_alloc", gnt_alloc, 4'b1000);
    checkOutput("t5 gnt_dealloc", gnt_dealloc, 4'b1000);
    checkOutput("t5 alloc_id", alloc_id, 16'h0042);
    checkOutput("t5 held_cnt3 unchanged", held_cnt[15:12], 2);
    req_alloc = '0; req_dealloc = '0;
    repeat (3) applyStimulus();

    // 6: reset during alloc WAIT, then a stale ack is ignored
    applyReset();
    req_alloc = 4'b0001;
    applyStimulus();
    checkOutput("t6 pulse before reset", fl_alloc_req, 1);
    rst_n = 1'b0; req_alloc = '0;
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    fl_alloc_ack = 1'b1; fl_alloc_id = 16'h0077;
    applyStimulus();
    fl_alloc_ack = 1'b0;
    checkOutput("t6 no grant on stale ack", gnt_alloc, 0);
    applyStimulus();
    checkOutput("t6 still no grant", gnt_alloc, 0);
    checkOutput("t6 counts zero", held_cnt, 0);

    // Randomized traffic with variable free-list latency and init_done drops
    applyReset();
    autoAck = 1'b1; ackMin = 0; ackMax = 3; fl_init_done = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_alloc[i]) req_alloc[i] = 1'b0;
        else if (!req_alloc[i] && $urandom_range(3, 0) == 0) req_alloc[i] = 1'b1;
        if (gnt_dealloc[i]) req_dealloc[i] = 1'b0;
        else if (!req_dealloc[i] && $urandom_range(5, 0) == 0) begin
          req_dealloc[i] = 1'b1;
          dealloc_id_in[i*IDW +: IDW] = IDW'($urandom);
        end
      end
      if (fl_init_done && $urandom_range(59, 0) == 0) fl_init_done = 1'b0;
      else if (!fl_init_done && $urandom_range(4, 0) == 0) fl_init_done = 1'b1;
    end
    req_alloc = '0; req_dealloc = '0;
    repeat (12) applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
